// File: rtl/tim_apb_pkg.sv
// Shared types and timer register map for the timer APB requester.
package tim_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [11:0] TCR   = 12'h000;
  localparam logic [11:0] TDR0  = 12'h004;
  localparam logic [11:0] TDR1  = 12'h008;
  localparam logic [11:0] TCMP0 = 12'h00C;
  localparam logic [11:0] TCMP1 = 12'h010;
  localparam logic [11:0] TIER  = 12'h014;
  localparam logic [11:0] TISR  = 12'h018;
  localparam logic [11:0] THCSR = 12'h01C;

endpackage

// File: rtl/tim_apb_wdog.sv
// Wait-state watchdog: counts ACCESS cycles with pready low, saturating at TIMEOUT.
// expired flags the increment that makes the count reach TIMEOUT, so the abort lands on that edge.
module tim_apb_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt <= '0;
        else if (clr)
          cnt <= '0;
        else if (inc && (cnt != MAX))
          cnt <= cnt + 1'b1;
      end

      assign expired = inc && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/tim_apb_master.sv
// APB4 requester for the timer slave: one command in flight, wait states honoured, watchdog abort.
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or watchdog expiry
// RESP   | rsp_valid held until rsp_ready
module tim_apb_master
  import tim_apb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [DATA_W-1:0]     tim_pwdata,
  output logic [DATA_W/8-1:0]   tim_pstrb,
  input  logic                  tim_pready,
  input  logic [DATA_W-1:0]     tim_prdata,
  input  logic                  tim_pslverr
);

  state_t state, state_nx;

  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                to_q;

  logic wd_clr;
  logic wd_inc;
  logic wd_expired;

  assign wd_clr = (state == ST_IDLE) && cmd_valid;
  assign wd_inc = (state == ST_ACCESS) && !tim_pready;

  tim_apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (tim_pready || wd_expired) state_nx = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && cmd_valid) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        strb_q  <= cmd_write ? cmd_strb : '0;
      end
      // pslverr only counts on the completing ACCESS cycle
      if (state == ST_ACCESS) begin
        if (tim_pready) begin
          rdata_q <= wr_q ? '0 : tim_prdata;
          err_q   <= tim_pslverr;
          to_q    <= 1'b0;
        end else if (wd_expired) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          to_q    <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign tim_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign tim_penable = (state == ST_ACCESS);
  assign tim_pwrite  = wr_q;
  assign tim_paddr   = addr_q;
  assign tim_pwdata  = wdata_q;
  assign tim_pstrb   = strb_q;

endmodule

// File: tb/tb_tim_apb_master.sv
// Randomized scoreboard bench for tim_apb_master with an APB slave model and watchdog checks.
module tb_tim_apb_master;
  import tim_apb_pkg::*;

  localparam int TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        tim_psel, tim_penable, tim_pwrite, tim_pready, tim_pslverr;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata, tim_prdata;
  logic [3:0]  tim_pstrb;

  tim_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_prdata(tim_prdata), .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall = 0;
  bit rnd_ready = 1'b0;

  always @(posedge sys_clk) cyc++;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } xact_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          at_cyc;
  } rsp_t;

  xact_t slv_q[$];
  rsp_t  exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic chk_bus(xact_t x);
    chk("paddr", 32'(tim_paddr), 32'(x.addr));
    chk("pwrite", 32'(tim_pwrite), 32'(x.wr));
    chk("pstrb", 32'(tim_pstrb), x.wr ? 32'(x.strb) : 32'd0);
    if (x.wr) chk("pwdata", tim_pwdata, x.wdata);
  endtask

  // Caller is aligned to posedge+2; returns at posedge+2 just after the accept edge.
  task automatic issue(bit wr, logic [11:0] a, logic [31:0] d, logic [3:0] s,
                       int w, logic [31:0] rd, bit er);
    int n = 0;
    xact_t x;
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    @(negedge sys_clk);
    while (!cmd_ready && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    x.wr = wr; x.addr = a; x.wdata = d; x.strb = s; x.waits = w; x.rdata = rd; x.err = er;
    slv_q.push_back(x);
    if (w >= TIMEOUT) begin
      e.rdata = 32'd0; e.err = 1'b1; e.to = 1'b1; e.at_cyc = cyc + 3 + (TIMEOUT - 1);
    end else begin
      e.rdata = wr ? 32'd0 : rd; e.err = er; e.to = 1'b0; e.at_cyc = cyc + 3 + w;
    end
    exp_q.push_back(e);
    @(posedge sys_clk);
    #2;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 12'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step(1);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // APB slave model: pready rises on ACCESS cycle index == waits; garbage elsewhere.
  initial begin
    xact_t cur;
    int ac = 0;
    bit have = 1'b0;
    tim_pready = 1'b0;
    tim_prdata = '0;
    tim_pslverr = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tim_psel && !tim_penable) begin
        if (slv_q.size() == 0) begin
          chk("unexpected_setup", 32'(slv_q.size()), 32'd1);
          have = 1'b0;
        end else begin
          cur = slv_q.pop_front();
          have = 1'b1;
          ac = 0;
          chk_bus(cur);
        end
        tim_pready = 1'($urandom);
        tim_prdata = $urandom;
        tim_pslverr = 1'($urandom);
      end else if (tim_psel && tim_penable && have) begin
        chk_bus(cur);
        if (ac == cur.waits) begin
          tim_pready = 1'b1;
          tim_prdata = cur.rdata;
          tim_pslverr = cur.err;
        end else begin
          tim_pready = 1'b0;
          tim_prdata = $urandom;
          tim_pslverr = 1'($urandom);
        end
        ac++;
      end else begin
        tim_pready = 1'($urandom);
        tim_prdata = $urandom;
        tim_pslverr = 1'($urandom);
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (stall > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) stall--;
      end else begin
        rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Response monitor: pops on the first cycle of each response, then checks it holds.
  initial begin
    rsp_t e;
    bit pend = 1'b0;
    bit post_hs = 1'b0;
    logic [31:0] hr;
    logic he, ht;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        pend = 1'b0;
        post_hs = 1'b0;
      end else begin
        if (post_hs) begin
          chk("idle_after_hs", {30'd0, rsp_valid, cmd_ready}, 32'd1);
          post_hs = 1'b0;
        end else if (rsp_valid) begin
          if (!pend) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
              chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
              chk("rsp_cycle", 32'(cyc), 32'(e.at_cyc));
            end
            hr = rsp_rdata; he = rsp_err; ht = rsp_timeout;
            pend = 1'b1;
          end else begin
            chk("hold_rdata", rsp_rdata, hr);
            chk("hold_flags", {30'd0, rsp_err, rsp_timeout}, {30'd0, he, ht});
          end
          chk("resp_quiet", {29'd0, cmd_ready, tim_psel, tim_penable}, 32'd0);
          if (rsp_ready) begin
            pend = 1'b0;
            post_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    bit wr;
    int w;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    step(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_ctrl", {25'd0, tim_psel, tim_penable, tim_pwrite, rsp_valid, rsp_err, rsp_timeout, busy}, 32'd0);
    chk("rst_paddr", 32'(tim_paddr), 32'd0);
    chk("rst_pwdata", tim_pwdata, 32'd0);
    chk("rst_pstrb", 32'(tim_pstrb), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    sys_rst_n = 1'b1;
    step(1);

    issue(1'b1, TCR, 32'h0000_0003, 4'hF, 0, 32'h0, 1'b0);
    drain();
    issue(1'b0, TDR0, 32'h5555_AAAA, 4'hF, 3, 32'hDEAD_BEEF, 1'b0);
    drain();
    issue(1'b1, TCR, 32'h0000_0900, 4'hF, 0, 32'h0, 1'b1);
    drain();
    issue(1'b0, TCMP0, 32'h0, 4'h0, TIMEOUT, 32'hCAFE_F00D, 1'b0);
    drain();
    issue(1'b0, TCMP1, 32'h0, 4'h0, TIMEOUT - 1, 32'h1234_5678, 1'b0);
    drain();
    stall = 5;
    issue(1'b1, TIER, 32'h0000_00FF, 4'h3, 1, 32'h0, 1'b0);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom);
      w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 20));
      issue(wr, 12'($urandom_range(0, 7) * 4), $urandom, 4'($urandom), w,
            $urandom, ($urandom_range(0, 3) == 0));
      step(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain();

    rnd_ready = 1'b0;
    issue(1'b0, TISR, 32'h0, 4'hF, 25, 32'h0BAD_0BAD, 1'b0);
    n = 0;
    while (!(tim_psel && tim_penable) && n < 20) begin
      step(1);
      n++;
    end
    chk("reach_access", {30'd0, tim_psel, tim_penable}, 32'd3);
    step(2);
    sys_rst_n = 1'b0;
    exp_q.delete();
    slv_q.delete();
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("midrst_ctrl", {28'd0, tim_psel, tim_penable, rsp_valid, busy}, 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    end
    issue(1'b0, THCSR, 32'h0, 4'hF, 1, 32'h0000_0A5A, 1'b0);
    drain();

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
